// File: rtl/seg_display_scan_if.sv
// seg_display_scan_if
//   Bus between the panel controller and the multiplexed 7-segment driver.
//   master : controller side, drives value/err_code/load/blank_lz and
//            observes seg/an/overflow.
//   slave  : display driver side.
//   value     VALUE_W     unsigned binary value to show
//   err_code  2           0 = no error, 1..3 = error code
//   load      1           1-cycle capture strobe
//   blank_lz  1           blank leading zero digits (normal mode)
//   seg       7           segments {a..g}, seg[6] = a, active-high
//   an        NUM_DIGITS  one-hot digit enable, an[0] = least significant
//   overflow  1           latched value does not fit in NUM_DIGITS hex digits
interface seg_display_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 11
);
  logic [VALUE_W-1:0]    value;
  logic [1:0]            err_code;
  logic                  load;
  logic                  blank_lz;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  overflow;

  modport master (
    output value, err_code, load, blank_lz,
    input  seg, an, overflow
  );

  modport slave (
    input  value, err_code, load, blank_lz,
    output seg, an, overflow
  );
endinterface

// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Time-multiplexed NUM_DIGITS-digit 7-segment driver. A value and error
//   code are captured on load and shown in hex, one digit per refresh slot.
//   Error codes replace the value with 'E' + code; a value too large for the
//   digits raises overflow and shows 'E' + '4'.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : seg_display_scan_if.slave (value, err_code, load, blank_lz in;
//          seg, an, overflow out)
module seg_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 11,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_display_scan_if.slave    bus
);

  localparam int EXT_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [6:0] GLYPH_E   = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  // Only the displayable nibbles are kept; anything above them is folded
  // into the overflow flag at capture time.
  logic [EXT_W-1:0] value_in_ext;
  logic             ovf_in;

  generate
    if (VALUE_W > EXT_W) begin : g_wide
      assign value_in_ext = bus.value[EXT_W-1:0];
      assign ovf_in       = |bus.value[VALUE_W-1:EXT_W];
    end else if (VALUE_W == EXT_W) begin : g_exact
      assign value_in_ext = bus.value;
      assign ovf_in       = 1'b0;
    end else begin : g_narrow
      assign value_in_ext = {{(EXT_W-VALUE_W){1'b0}}, bus.value};
      assign ovf_in       = 1'b0;
    end
  endgenerate

  logic [EXT_W-1:0]      shadow_value_reg;
  logic [1:0]            shadow_code_reg;
  logic                  overflow_reg;
  logic [CNT_W-1:0]      refresh_cnt_reg, refresh_cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [6:0]            seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;

  // Per-digit nibble and "this digit and everything above it is zero".
  logic [3:0]            nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi]     = shadow_value_reg[4*gi +: 4];
      assign upper_zero[gi] = ~|shadow_value_reg[EXT_W-1:4*gi];
    end
  endgenerate

  logic       refresh_tick;
  logic       idx_is_last;
  logic       idx_is_first;
  logic [3:0] cur_nibble;
  logic       cur_upper_zero;

  always_comb begin
    refresh_tick     = (refresh_cnt_reg == CNT_W'(REFRESH_DIV - 1));
    refresh_cnt_next = refresh_tick ? '0 : refresh_cnt_reg + 1'b1;
    idx_is_last      = (idx_reg == IDX_W'(NUM_DIGITS - 1));
    idx_is_first     = (idx_reg == '0);
    idx_next         = idx_reg;
    if (refresh_tick) begin
      idx_next = idx_is_last ? '0 : idx_reg + 1'b1;
    end

    cur_nibble     = 4'h0;
    cur_upper_zero = 1'b0;
    an_next        = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        cur_nibble     = nibble[i];
        cur_upper_zero = upper_zero[i];
        an_next[i]     = 1'b1;
      end
    end

    // Error screens take priority over the value; blanked digits keep their
    // anode enabled and just drive all segments off.
    seg_next = SEG_BLANK;
    if (overflow_reg || (shadow_code_reg != 2'd0)) begin
      if (idx_is_last) begin
        seg_next = GLYPH_E;
      end else if (idx_is_first) begin
        seg_next = overflow_reg ? glyph(4'h4) : glyph({2'b00, shadow_code_reg});
      end
    end else if (!(bus.blank_lz && !idx_is_first && cur_upper_zero)) begin
      seg_next = glyph(cur_nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_value_reg <= '0;
      shadow_code_reg  <= '0;
      overflow_reg     <= 1'b0;
      refresh_cnt_reg  <= '0;
      idx_reg          <= '0;
      seg_reg          <= '0;
      an_reg           <= '0;
    end else begin
      if (bus.load) begin
        shadow_value_reg <= value_in_ext;
        shadow_code_reg  <= bus.err_code;
        overflow_reg     <= ovf_in;
      end
      refresh_cnt_reg <= refresh_cnt_next;
      idx_reg         <= idx_next;
      seg_reg         <= seg_next;
      an_reg          <= an_next;
    end
  end

  assign bus.seg      = seg_reg;
  assign bus.an       = an_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_seg_display_scan.sv
module tb_seg_display_scan;

  localparam int ND   = 4;
  localparam int VW_A = 11;
  localparam int RD_A = 4;
  localparam int VW_B = 20;
  localparam int RD_B = 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seg_display_scan_if #(.NUM_DIGITS(ND), .VALUE_W(VW_A)) bus_a ();
  seg_display_scan_if #(.NUM_DIGITS(ND), .VALUE_W(VW_B)) bus_b ();

  seg_display_scan #(.NUM_DIGITS(ND), .VALUE_W(VW_A), .REFRESH_DIV(RD_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seg_display_scan #(.NUM_DIGITS(ND), .VALUE_W(VW_B), .REFRESH_DIV(RD_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference: what digit d should show for a latched (value, code).
  function automatic logic [6:0] model_seg(input logic [31:0] v, input logic [1:0] c,
                                           input bit ovf, input bit blz, input int d);
    if (ovf || c != 2'd0) begin
      if (d == ND - 1) return glyph_tab[14];
      if (d == 0)      return ovf ? glyph_tab[4] : glyph_tab[c];
      return 7'b0000000;
    end
    if (blz && d != 0 && (v >> (4 * d)) == 32'd0) return 7'b0000000;
    return glyph_tab[(v >> (4 * d)) & 32'hF];
  endfunction

  function automatic bit model_ovf(input logic [31:0] v);
    return 64'(v) >= (64'd1 << (4 * ND));
  endfunction

  // Reference state per DUT: edges since reset release, latched inputs and
  // the outputs expected after the most recent edge.
  int          a_cyc, b_cyc;
  logic [31:0] a_sv, b_sv;
  logic [1:0]  a_sc, b_sc;
  bit          a_ovf, b_ovf;
  logic [3:0]  a_exp_an, b_exp_an;
  logic [6:0]  a_exp_seg, b_exp_seg;

  always @(posedge clk) begin
    if (rst) begin
      a_cyc = 0; a_sv = 0; a_sc = 0; a_ovf = 0; a_exp_an = 0; a_exp_seg = 0;
    end else begin
      a_exp_an  = 4'(1 << ((a_cyc / RD_A) % ND));
      a_exp_seg = model_seg(a_sv, a_sc, a_ovf, bus_a.blank_lz, (a_cyc / RD_A) % ND);
      a_cyc++;
      if (bus_a.load) begin
        a_sv  = 32'(bus_a.value);
        a_sc  = bus_a.err_code;
        a_ovf = model_ovf(a_sv);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      b_cyc = 0; b_sv = 0; b_sc = 0; b_ovf = 0; b_exp_an = 0; b_exp_seg = 0;
    end else begin
      b_exp_an  = 4'(1 << ((b_cyc / RD_B) % ND));
      b_exp_seg = model_seg(b_sv, b_sc, b_ovf, bus_b.blank_lz, (b_cyc / RD_B) % ND);
      b_cyc++;
      if (bus_b.load) begin
        b_sv  = 32'(bus_b.value);
        b_sc  = bus_b.err_code;
        b_ovf = model_ovf(b_sv);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus_a.value = '0; bus_a.err_code = 0; bus_a.load = 0; bus_a.blank_lz = 0;
    bus_b.value = '0; bus_b.err_code = 0; bus_b.load = 0; bus_b.blank_lz = 0;
    repeat (3) @(negedge clk);
    total++;
    if (bus_a.an !== 4'b0000 || bus_a.seg !== 7'b0000000 || bus_a.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_a got an=%b seg=%b ovf=%b want an=0000 seg=0000000 ovf=0",
               bus_a.an, bus_a.seg, bus_a.overflow);
    end
    total++;
    if (bus_b.an !== 4'b0000 || bus_b.seg !== 7'b0000000 || bus_b.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_b got an=%b seg=%b ovf=%b want an=0000 seg=0000000 ovf=0",
               bus_b.an, bus_b.seg, bus_b.overflow);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus_a.an !== 4'b0001 || bus_a.seg !== 7'b1111110) begin
      bad++;
      $display("FAIL first_after_reset got an=%b seg=%b want an=0001 seg=1111110",
               bus_a.an, bus_a.seg);
    end
    $display("reset released");
  endtask

  task automatic test_scan(input bit blz, input logic [10:0] val);
    @(negedge clk);
    bus_a.value = val; bus_a.err_code = 0; bus_a.blank_lz = blz; bus_a.load = 1;
    $display("load a value=0x%03h code=0 blank_lz=%0d", val, blz);
    @(negedge clk);
    bus_a.load = 0;
    repeat (2 * ND * RD_A) begin
      @(negedge clk);
      total++;
      if (bus_a.an !== a_exp_an || bus_a.seg !== a_exp_seg) begin
        bad++;
        $display("FAIL scan_model got an=%b seg=%b want an=%b seg=%b",
                 bus_a.an, bus_a.seg, a_exp_an, a_exp_seg);
      end
    end
  endtask

  task automatic test_scan_table();
    logic [6:0] want;
    @(negedge clk);
    bus_a.value = 11'h02A; bus_a.err_code = 0; bus_a.blank_lz = 0; bus_a.load = 1;
    $display("load a value=0x02a code=0 blank_lz=0 (glyph table)");
    @(negedge clk);
    bus_a.load = 0;
    repeat (ND * RD_A) begin
      @(negedge clk);
      case (bus_a.an)
        4'b0001: want = 7'b1110111;
        4'b0010: want = 7'b1101101;
        default: want = 7'b1111110;
      endcase
      total++;
      if (bus_a.seg !== want || $countones(bus_a.an) != 1) begin
        bad++;
        $display("FAIL scan_02a got an=%b seg=%b want seg=%b one-hot", bus_a.an, bus_a.seg, want);
      end
    end
  endtask

  task automatic test_error();
    @(negedge clk);
    bus_a.value = 11'h123; bus_a.err_code = 2; bus_a.blank_lz = 0; bus_a.load = 1;
    $display("load a value=0x123 code=2");
    @(negedge clk);
    bus_a.load = 0;
    bus_a.value = 11'h7FF;  // not loaded: must not affect display
    repeat (ND * RD_A) begin
      @(negedge clk);
      total++;
      if (bus_a.an !== a_exp_an || bus_a.seg !== a_exp_seg) begin
        bad++;
        $display("FAIL error_screen got an=%b seg=%b want an=%b seg=%b",
                 bus_a.an, bus_a.seg, a_exp_an, a_exp_seg);
      end
      if (bus_a.an == 4'b1000) begin
        total++;
        if (bus_a.seg !== 7'b1001111) begin
          bad++;
          $display("FAIL error_E got seg=%b want 1001111", bus_a.seg);
        end
      end
    end
    bus_a.value = 11'h123; bus_a.err_code = 0; bus_a.load = 1;
    $display("load a value=0x123 code=0");
    @(negedge clk);
    bus_a.load = 0;
    repeat (ND * RD_A) begin
      @(negedge clk);
      total++;
      if (bus_a.an !== a_exp_an || bus_a.seg !== a_exp_seg) begin
        bad++;
        $display("FAIL error_clear got an=%b seg=%b want an=%b seg=%b",
                 bus_a.an, bus_a.seg, a_exp_an, a_exp_seg);
      end
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    bus_b.value = 20'h12345; bus_b.err_code = 3; bus_b.blank_lz = 0; bus_b.load = 1;
    $display("load b value=0x12345 code=3");
    @(negedge clk);
    bus_b.load = 0;
    total++;
    if (bus_b.overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set got %b want 1", bus_b.overflow);
    end
    repeat (2 * ND) begin
      @(negedge clk);
      total++;
      if (bus_b.an !== b_exp_an || bus_b.seg !== b_exp_seg) begin
        bad++;
        $display("FAIL overflow_screen got an=%b seg=%b want an=%b seg=%b",
                 bus_b.an, bus_b.seg, b_exp_an, b_exp_seg);
      end
      if (bus_b.an == 4'b0001) begin
        total++;
        if (bus_b.seg !== 7'b0110011) begin
          bad++;
          $display("FAIL overflow_4 got seg=%b want 0110011", bus_b.seg);
        end
      end
    end
    bus_b.value = 20'h0FFFF; bus_b.err_code = 0; bus_b.load = 1;
    $display("load b value=0x0ffff code=0");
    @(negedge clk);
    bus_b.load = 0;
    total++;
    if (bus_b.overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear got %b want 0", bus_b.overflow);
    end
    repeat (2 * ND) begin
      @(negedge clk);
      total++;
      if (bus_b.seg !== 7'b1000111 || bus_b.an !== b_exp_an) begin
        bad++;
        $display("FAIL all_F got an=%b seg=%b want an=%b seg=1000111",
                 bus_b.an, bus_b.seg, b_exp_an);
      end
    end
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus_b.value = 20'(k); bus_b.err_code = 0; bus_b.blank_lz = 0; bus_b.load = 1;
      $display("load b value=0x%0h code=0 (sweep)", k);
      @(negedge clk);
      bus_b.load = 0;
      repeat (ND) begin
        @(negedge clk);
        if (bus_b.an == 4'b0001) begin
          total++;
          if (bus_b.seg !== glyph_tab[k]) begin
            bad++;
            $display("FAIL sweep_%0h got seg=%b want %b", k, bus_b.seg, glyph_tab[k]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      total++;
      if (bus_a.an !== a_exp_an || bus_a.seg !== a_exp_seg || bus_a.overflow !== a_ovf) begin
        bad++;
        $display("FAIL random_a got an=%b seg=%b ovf=%b want an=%b seg=%b ovf=%b",
                 bus_a.an, bus_a.seg, bus_a.overflow, a_exp_an, a_exp_seg, a_ovf);
      end
      total++;
      if (bus_b.an !== b_exp_an || bus_b.seg !== b_exp_seg || bus_b.overflow !== b_ovf) begin
        bad++;
        $display("FAIL random_b got an=%b seg=%b ovf=%b want an=%b seg=%b ovf=%b",
                 bus_b.an, bus_b.seg, bus_b.overflow, b_exp_an, b_exp_seg, b_ovf);
      end
      bus_a.load = ($urandom_range(0, 11) == 0);
      bus_b.load = ($urandom_range(0, 11) == 0);
      bus_a.value    = 11'($urandom >> $urandom_range(0, 10));
      bus_b.value    = 20'($urandom >> $urandom_range(0, 19));
      bus_a.err_code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus_b.err_code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if ($urandom_range(0, 15) == 0) bus_a.blank_lz = ~bus_a.blank_lz;
      if ($urandom_range(0, 15) == 0) bus_b.blank_lz = ~bus_b.blank_lz;
      if (bus_a.load)
        $display("load a value=0x%03h code=%0d blank_lz=%0d", bus_a.value, bus_a.err_code, bus_a.blank_lz);
      if (bus_b.load)
        $display("load b value=0x%05h code=%0d blank_lz=%0d", bus_b.value, bus_b.err_code, bus_b.blank_lz);
    end
    @(negedge clk);
    bus_a.load = 0; bus_b.load = 0;
  endtask

  task automatic test_mid_reset();
    int budget = 0;
    @(negedge clk);
    bus_a.value = 11'h5A3; bus_a.err_code = 0; bus_a.blank_lz = 0; bus_a.load = 1;
    $display("load a value=0x5a3 code=0");
    @(negedge clk);
    bus_a.load = 0;
    while (((a_cyc / RD_A) % ND) != 2 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    total++;
    if (budget >= 100) begin
      bad++;
      $display("FAIL mid_reset_wait got timeout want idx=2");
    end
    rst = 1'b1; bus_a.load = 1; bus_a.value = 11'h007;
    $display("reset with load a value=0x007");
    @(negedge clk);
    total++;
    if (bus_a.an !== 4'b0000 || bus_a.seg !== 7'b0000000 || bus_a.overflow !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got an=%b seg=%b ovf=%b want an=0000 seg=0000000 ovf=0",
               bus_a.an, bus_a.seg, bus_a.overflow);
    end
    rst = 1'b0; bus_a.load = 0;
    @(negedge clk);
    total++;
    if (bus_a.an !== 4'b0001 || bus_a.seg !== 7'b1111110) begin
      bad++;
      $display("FAIL after_mid_reset got an=%b seg=%b want an=0001 seg=1111110",
               bus_a.an, bus_a.seg);
    end
    repeat (ND * RD_A) begin
      @(negedge clk);
      total++;
      if (bus_a.an !== a_exp_an || bus_a.seg !== 7'b1111110) begin
        bad++;
        $display("FAIL shadow_cleared got an=%b seg=%b want an=%b seg=1111110",
                 bus_a.an, bus_a.seg, a_exp_an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_table();
    test_scan(1'b0, 11'h02A);
    test_scan(1'b1, 11'h02A);
    test_scan(1'b1, 11'h000);
    test_error();
    test_overflow();
    test_sweep();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
